// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that assembles a framed byte stream into instruction memory writes.
// Frame: A5, N[7:0], N[15:8], 4*N little-endian data bytes, XOR-of-data checksum.
module imem_loader #(
  parameter int unsigned MEM_DEPTH_WORDS = 4096,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic        clk,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        prog_en,
  output logic [31:0] prog_addr,
  output logic [31:0] prog_data,
  output logic        core_start,
  output logic        busy,
  output logic        error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam logic [7:0] HDR = 8'hA5;

  // Gap counter spans 0..TIMEOUT_CYCLES-1; the last value triggers the timeout.
  localparam int unsigned       GAP_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      widx_q, widx_d;
  logic [1:0]       bidx_q, bidx_d;
  logic [31:0]      word_q, word_d;
  logic [7:0]       csum_q, csum_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             rdy_q, rdy_d;
  logic             prog_en_q, prog_en_d;
  logic [31:0]      prog_addr_q, prog_addr_d;
  logic [31:0]      prog_data_q, prog_data_d;

  logic        take;
  logic        in_frame;
  logic [31:0] len_full;
  logic [31:0] word_ins;
  logic [15:0] widx_inc;

  always_comb begin
    take     = rx_valid && rdy_q;
    in_frame = (state_q == S_LEN0) || (state_q == S_LEN1) ||
               (state_q == S_DATA) || (state_q == S_CHECK);
    len_full = {16'h0000, rx_data, len_q[7:0]};
    widx_inc = widx_q + 16'd1;
    word_ins = word_q;
    word_ins[{bidx_q, 3'b000} +: 8] = rx_data;

    state_d     = state_q;
    len_d       = len_q;
    widx_d      = widx_q;
    bidx_d      = bidx_q;
    word_d      = word_q;
    csum_d      = csum_q;
    rdy_d       = 1'b1;
    prog_en_d   = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;

    gap_d = '0;
    if (in_frame && !take) begin
      gap_d = gap_q + GAP_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (take && rx_data == HDR) begin
          state_d = S_LEN0;
        end
      end
      S_LEN0: begin
        if (take) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (take) begin
          len_d[15:8] = rx_data;
          widx_d      = '0;
          bidx_d      = '0;
          word_d      = '0;
          csum_d      = '0;
          if (len_full > MEM_DEPTH_WORDS) begin
            state_d = S_ERR;
          end else if (len_full == 32'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (take) begin
          word_d = word_ins;
          csum_d = csum_q ^ rx_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            prog_en_d   = 1'b1;
            prog_addr_d = {14'b0, widx_q, 2'b00};
            prog_data_d = word_ins;
            widx_d      = widx_inc;
            if (widx_inc == len_q) begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (take) begin
          state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
        end
      end
      S_RUN, S_ERR: begin
        if (take && rx_data == HDR) begin
          state_d = S_LEN0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A partially assembled word is simply abandoned; nothing is written on timeout.
    if (in_frame && !take && gap_q == GAP_LAST) begin
      state_d = S_ERR;
    end
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      widx_q      <= '0;
      bidx_q      <= '0;
      word_q      <= '0;
      csum_q      <= '0;
      gap_q       <= '0;
      rdy_q       <= 1'b0;
      prog_en_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      widx_q      <= widx_d;
      bidx_q      <= bidx_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      gap_q       <= gap_d;
      rdy_q       <= rdy_d;
      prog_en_q   <= prog_en_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
    end
  end

  assign rx_ready   = rdy_q;
  assign prog_en    = prog_en_q;
  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign core_start = (state_q == S_RUN);
  assign error      = (state_q == S_ERR);
  assign busy       = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CHECK);

endmodule
